// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with private HI/LO registers.
// One radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;       // product / quotient sign
  logic                 neg_r_q, neg_r_d;   // remainder sign (follows dividend)
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;

  // Operand conditioning at start
  logic                 op_signed;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a_in, mag_b_in;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sign_a    = op_signed & opA[WIDTH-1];
  assign sign_b    = op_signed & opB[WIDTH-1];
  assign mag_a_in  = sign_a ? (~opA + 1'b1) : opA;
  assign mag_b_in  = sign_b ? (~opB + 1'b1) : opB;

  // Multiply step: low half of acc holds the remaining multiplier bits
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half fills with quotient bits
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;

  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, mag_b_q});
  assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  // Sign correction applied in FIN
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 b_zero;

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  assign b_zero   = (mag_b_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    opa_d    = opa_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = (op == OP_DIV) || (op == OP_DIVU);
              neg_d    = sign_a ^ sign_b;
              neg_r_d  = sign_a;
              opa_d    = opA;
              mag_b_d  = mag_b_in;
              acc_d    = {{WIDTH{1'b0}}, mag_a_in};
              cnt_d    = '0;
              state_d  = CALC;
            end
            OP_MTHI: begin
              hi_d   = opA;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = opA;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        if (is_div_q) begin
          // Most-negative / -1 falls out naturally: magnitude 2^(W-1) re-negates to itself
          if (b_zero) begin
            hi_d = opa_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          dbz_d = b_zero;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      opa_q    <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      opa_q    <= opa_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed ops queue expected results,
// a forked monitor pops and compares on every done pulse.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opA, opB;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           bsy;
    int           e0;
  } exp_t;

  exp_t sb_q[$];

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one start cycle. elat < 0 means no done expected.
  task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edbz, input int elat, input int ebsy);
    exp_t e;
    start = 1'b1; op = o; opA = a; opB = b;
    if (elat >= 0) begin
      e.name = name; e.hi = ehi; e.lo = elo; e.dbz = edbz;
      e.lat = elat; e.bsy = ebsy; e.e0 = cyc + 1;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; op = 3'd7; opA = 32'hDEAD_BEEF; opB = 32'h0BAD_F00D;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout: got done=0 expected done=1", name);
    end
  endtask

  initial begin
    int bcnt;
    exp_t e;

    rst = 1'b1; start = 1'b0; op = 3'd0; opA = '0; opB = '0;

    fork
      begin
        bcnt = 0;
        forever begin
          @(posedge clk);
          #1;
          if (rst) begin
            bcnt = 0;
          end else begin
            if (busy) bcnt++;
            if (done) begin
              if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
              end else begin
                e = sb_q.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
                chk({e.name, "_dbz"}, div_by_zero, e.dbz);
                chk({e.name, "_latency"}, cyc - e.e0, e.lat);
                chk({e.name, "_busy_cycles"}, bcnt, e.bsy);
              end
              bcnt = 0;
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);

    // MULT -3 * 5
    issue("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33, 33);
    wait_empty("mult_neg");

    // MULTU max*max, then DIV -7/2 started in the done cycle
    issue("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 33);
    wait_done("multu_max");
    issue("div_b2b", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 33);
    wait_empty("div_b2b");

    // Signed overflow
    @(negedge clk);
    issue("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 33);
    wait_empty("div_ovf");

    // DIVU by zero
    @(negedge clk);
    issue("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 33, 33);
    wait_empty("divu_zero");

    // MTHI then MTLO
    @(negedge clk);
    issue("mthi", 3'd4, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 0, 0);
    chk("mthi_hi_at_e0", hi, 32'hA5A5_A5A5);
    chk("mthi_busy", busy, 0);
    chk("mthi_done_next", done, 1);
    wait_empty("mthi");
    issue("mtlo", 3'd5, 32'h5A5A_5A5A, 32'd0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 0, 0);
    wait_empty("mtlo");

    // DIVU 100/7 with a stray MTHI start pulsed mid-CALC
    @(negedge clk);
    issue("divu_stray", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 33);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd4; opA = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    wait_empty("divu_stray");

    // No-op code: nothing changes, no done
    @(negedge clk);
    issue("noop6", 3'd6, 32'h1111_1111, 32'h2222_2222, '0, '0, 1'b0, -1, 0);
    repeat (3) @(negedge clk);
    chk("noop6_hi", hi, 32'd2);
    chk("noop6_lo", lo, 32'd14);

    // Reset 10 cycles into a DIVU
    issue("divu_abort", 3'd3, 32'h0000_1000, 32'd3, '0, '0, 1'b0, 33, 33);
    repeat (9) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    sb_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);

    issue("multu_small", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 33);
    wait_empty("multu_small");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
